// File: rtl/ov7670_capture_if.sv
// Camera byte stream in, frame-buffer write port out.
// OV7670_CAPTURE_TEST_PATTERN_EN adds the test_pattern select.
interface ov7670_capture_if #(
  parameter int AW = 20
);
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          capture_en;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic          test_pattern;
`endif
  logic [AW-1:0] w_addr;
  logic [11:0]   w_data;
  logic          w_en;
  logic          frame_done;
  logic          line_err;
  logic          overflow;

  modport master (
    output cam_vsync, cam_href, cam_data, capture_en,
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    output test_pattern,
`endif
    input  w_addr, w_data, w_en, frame_done, line_err, overflow
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data, capture_en,
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    input  test_pattern,
`endif
    output w_addr, w_data, w_en, frame_done, line_err, overflow
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels, writes them linearly.
// Optional macro OV7670_CAPTURE_TEST_PATTERN_EN replaces pixels with 8 vertical colour bars.
module ov7670_capture #(
  parameter int RESOLUTION_WIDTH  = 640,
  parameter int RESOLUTION_HEIGHT = 480,
  parameter int AW = $clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)+1
) (
  input logic             pclk,
  input logic             rst,
  ov7670_capture_if.slave cam
);
  localparam int NPIX = RESOLUTION_WIDTH*RESOLUTION_HEIGHT;
  localparam int PW   = $clog2(RESOLUTION_WIDTH+1)+1;
  localparam int LW   = $clog2(RESOLUTION_HEIGHT+1)+1;

  typedef enum logic [1:0] {WAIT_VS, BLANK, ACTIVE} state_t;
  state_t state;

  logic          vs_q, vs_d, href_q, href_d;
  logic [7:0]    data_q;
  logic          phase_lo;
  logic [3:0]    r_hi;
  logic [AW-1:0] nxt_addr;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          clr_pend;

  logic          frame_start, line_end, line_bad, err_eff;
  logic [LW-1:0] line_cnt_eff;
  logic [11:0]   pixel;

  assign frame_start = vs_q & ~vs_d;

  // A frame start while href is still high closes the line before the frame.
  always_comb begin
    line_end     = (state == ACTIVE) && ((href_d && !href_q) || (frame_start && href_q));
    line_bad     = phase_lo || (pix_cnt != PW'(RESOLUTION_WIDTH));
    line_cnt_eff = line_cnt;
    err_eff      = cam.line_err;
    if (line_end) begin
      if (line_cnt != '1) line_cnt_eff = line_cnt + LW'(1);
      if (line_bad) err_eff = 1'b1;
    end
  end

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar   = 3'((32'(pix_cnt) * 8) / RESOLUTION_WIDTH);
    pixel = cam.test_pattern ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : {r_hi, data_q};
  end
`else
  assign pixel = {r_hi, data_q};
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q           <= 1'b0;
      vs_d           <= 1'b0;
      href_q         <= 1'b0;
      href_d         <= 1'b0;
      data_q         <= '0;
      state          <= WAIT_VS;
      phase_lo       <= 1'b0;
      r_hi           <= '0;
      nxt_addr       <= '0;
      pix_cnt        <= '0;
      line_cnt       <= '0;
      clr_pend       <= 1'b0;
      cam.w_addr     <= '0;
      cam.w_data     <= '0;
      cam.w_en       <= 1'b0;
      cam.frame_done <= 1'b0;
      cam.line_err   <= 1'b0;
      cam.overflow   <= 1'b0;
    end else begin
      vs_q           <= cam.cam_vsync;
      vs_d           <= vs_q;
      href_q         <= cam.cam_href;
      href_d         <= href_q;
      data_q         <= cam.cam_data;
      cam.w_en       <= 1'b0;
      cam.frame_done <= 1'b0;
      // Flags of a finished frame stay visible alongside frame_done, then clear.
      if (clr_pend) begin
        cam.line_err <= 1'b0;
        cam.overflow <= 1'b0;
        clr_pend     <= 1'b0;
      end
      case (state)
        WAIT_VS: begin
          phase_lo <= 1'b0;
          if (frame_start && cam.capture_en) begin
            state        <= BLANK;
            nxt_addr     <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            cam.w_addr   <= '0;
            cam.line_err <= 1'b0;
            cam.overflow <= 1'b0;
          end
        end
        BLANK: begin
          phase_lo <= 1'b0;
          if (!vs_q) state <= ACTIVE;
        end
        ACTIVE: begin
          if (frame_start) begin
            cam.frame_done <= (line_cnt_eff == LW'(RESOLUTION_HEIGHT)) && !err_eff && !cam.overflow;
            cam.line_err   <= err_eff;
            phase_lo       <= 1'b0;
            pix_cnt        <= '0;
            if (cam.capture_en) begin
              state      <= BLANK;
              nxt_addr   <= '0;
              line_cnt   <= '0;
              cam.w_addr <= '0;
              clr_pend   <= 1'b1;
            end else begin
              state    <= WAIT_VS;
              line_cnt <= line_cnt_eff;
            end
          end else if (href_q) begin
            phase_lo <= ~phase_lo;
            if (!phase_lo) begin
              r_hi <= data_q[3:0];
            end else begin
              if (pix_cnt != '1) pix_cnt <= pix_cnt + PW'(1);
              if (nxt_addr < AW'(NPIX)) begin
                cam.w_en   <= 1'b1;
                cam.w_addr <= nxt_addr;
                cam.w_data <= pixel;
                nxt_addr   <= nxt_addr + AW'(1);
              end else begin
                cam.overflow <= 1'b1;
              end
            end
          end else begin
            phase_lo <= 1'b0;
            if (line_end) begin
              cam.line_err <= err_eff;
              line_cnt     <= line_cnt_eff;
              pix_cnt      <= '0;
            end
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture: frame-level model of expected writes, flags and frame_done.
`timescale 1ns/1ps
module tb_ov7670_capture;
  localparam int W = 4, H = 2, NPIX = W*H;
  localparam int AW = $clog2(NPIX)+1;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  ov7670_capture_if #(.AW(AW)) cam_if ();
  ov7670_capture #(.RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H), .AW(AW)) dut (
    .pclk(pclk), .rst(rst), .cam(cam_if)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          addr;
    int          data;
  } wr_t;
  wr_t obs_wr[$], exp_wr[$];
  int  obs_fd[$], exp_fd[$];

  always @(negedge pclk) begin
    if (cam_if.w_en === 1'b1) obs_wr.push_back('{cyc, int'(cam_if.w_addr), int'(cam_if.w_data)});
    if (cam_if.frame_done === 1'b1) obs_fd.push_back(cyc);
  end

  // frame-level model state
  bit cap_state = 0, m_err = 0, m_ovf = 0;
  int m_k = 0, m_lines = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      cam_if.cam_href = 1'b0;
      cam_if.cam_data = 8'($urandom);
    end
  endtask

  // A byte set after tick() at cycle c is sampled at c+1; its write shows at c+2.
  task automatic line(input int n, input bit fixed);
    logic [7:0] b, hi;
    hi = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      b = fixed ? ((i % 2 == 1) ? 8'h5C : 8'h0A) : 8'($urandom);
      cam_if.cam_href = 1'b1;
      cam_if.cam_data = b;
      if (i % 2 == 0) hi = b;
      else if (cap_state) begin
        if (m_k < NPIX) exp_wr.push_back('{cyc + 2, m_k, int'({hi[3:0], b})});
        else m_ovf = 1;
        m_k++;
      end
    end
    if (cap_state) begin
      m_lines++;
      if ((n % 2 != 0) || (n / 2 != W)) m_err = 1;
    end
    idle(3);
  endtask

  task automatic vsync(input bit en);
    bit done;
    tick();
    cam_if.capture_en = en;
    cam_if.cam_vsync  = 1'b1;
    cam_if.cam_href   = 1'b0;
    done = cap_state && (m_lines == H) && !m_err && !m_ovf;
    if (done) exp_fd.push_back(cyc + 2);
    tick(); tick();
    if (cap_state) begin
      chk("eof_line_err", cam_if.line_err, m_err);
      chk("eof_overflow", cam_if.overflow, m_ovf);
    end
    if (en) begin m_err = 0; m_ovf = 0; m_k = 0; m_lines = 0; end
    cap_state = en;
    tick();
    chk("sof_line_err", cam_if.line_err, m_err);
    chk("sof_overflow", cam_if.overflow, m_ovf);
    tick();
    cam_if.cam_vsync = 1'b0;
    idle(2);
  endtask

  task automatic flush();
    idle(4);
    chk("n_writes", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      chk("wr_cycle", obs_wr[i].c, exp_wr[i].c);
      chk("wr_addr", obs_wr[i].addr, exp_wr[i].addr);
      chk("wr_data", obs_wr[i].data, exp_wr[i].data);
    end
    chk("n_frame_done", obs_fd.size(), exp_fd.size());
    for (int i = 0; i < obs_fd.size() && i < exp_fd.size(); i++)
      chk("frame_done_cycle", obs_fd[i], exp_fd[i]);
    obs_wr.delete(); exp_wr.delete(); obs_fd.delete(); exp_fd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_addr"}, cam_if.w_addr, 0);
    chk({tag, "_w_data"}, cam_if.w_data, 0);
    chk({tag, "_w_en"}, cam_if.w_en, 0);
    chk({tag, "_frame_done"}, cam_if.frame_done, 0);
    chk({tag, "_line_err"}, cam_if.line_err, 0);
    chk({tag, "_overflow"}, cam_if.overflow, 0);
  endtask

  initial begin
    int nl;
    int lens[5] = '{8, 8, 7, 6, 8};
    cam_if.cam_vsync  = 1'b0;
    cam_if.cam_href   = 1'b0;
    cam_if.cam_data   = 8'h00;
    cam_if.capture_en = 1'b1;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    cam_if.test_pattern = 1'b0;
`endif
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // bytes before the first frame start are ignored
    line(8, 0);
    flush();

    // clean fixed-pattern frame
    vsync(1); line(8, 1); line(8, 1); flush();
    // odd-length line
    vsync(1); line(7, 0); line(8, 0); flush();
    // clean frame clears line_err
    vsync(1); line(8, 0); line(8, 0); flush();
    // three lines overflow the buffer
    vsync(1); line(8, 0); line(8, 0); line(8, 0); flush();
    // not captured; enabling mid-frame has no effect
    vsync(0); cam_if.capture_en = 1'b1; line(8, 0); line(8, 0); flush();
    vsync(1); line(8, 0); line(8, 0); flush();

    // reset after five writes
    vsync(1); line(8, 0); line(2, 0); flush();
    tick(); rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    cap_state = 0; m_err = 0; m_ovf = 0; m_k = 0; m_lines = 0;
    vsync(1); line(8, 0); line(8, 0); flush();

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      vsync(($urandom_range(0, 3) != 0));
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) line(lens[$urandom_range(0, 4)], 0);
      flush();
    end
    vsync(1);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
